// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared width default and FSM state encoding for the counter
//            load sequencer and its shadow checker.
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

   localparam int WIDTH_DEFAULT = 4;

   // 3-bit state encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_COUNT = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_FLUSH = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      LOAD  = ST_LOAD,
      COUNT = ST_COUNT,
      DONE  = ST_DONE,
      FLUSH = ST_FLUSH
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/counter_shadow_check.sv
`default_nettype none
// ============================================================================
// Module   : counter_shadow_check
// Purpose  : Shadow copy of the external counter value. Loaded when a run is
//            accepted, advanced on every issued increment, and compared with
//            the counter outputs while checking is enabled. Any divergence
//            sets a sticky flag that only clear removes.
// Revision : 1.0 - initial release
// ============================================================================
module counter_shadow_check
   import counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             capture,
   input  logic [WIDTH-1:0] capture_value,
   input  logic             advance,
   input  logic             check_en,
   input  logic [WIDTH-1:0] cnt_value,
   output logic             mismatch
);

   logic [WIDTH-1:0] shadow;

   // Shadow count follows the same load/increment sequence as the counter
   always_ff @(posedge clock) begin
      if (clear) begin
         shadow <= '0;
      end else if (capture) begin
         shadow <= capture_value;
      end else if (advance) begin
         shadow <= shadow + WIDTH'(1);
      end
   end

   // Sticky divergence flag, only evaluated while checking is enabled
   always_ff @(posedge clock) begin
      if (clear) begin
         mismatch <= 1'b0;
      end else if (check_en && (cnt_value != shadow)) begin
         mismatch <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/counter_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : counter_load_sequencer
// Purpose  : Control stage for a parallel-load counter. Accepts a start value
//            over valid/ready, issues a one-cycle load, increments until the
//            counter carries out, then reports done and the run length.
//            Abort cancels a run and clears the counter through a FLUSH cycle.
// Revision : 1.0 - initial release
// ============================================================================
module counter_load_sequencer
   import counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start_valid,
   input  logic [WIDTH-1:0] start_value,
   output logic             start_ready,
   input  logic             pause,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_value,
   input  logic             cnt_carry,
   output logic             cnt_clear,
   output logic             cnt_load,
   output logic             cnt_increment,
   output logic [WIDTH-1:0] cnt_data,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [WIDTH:0]   run_len,
   output logic             mismatch
);

   seq_state_t       state;
   logic [WIDTH-1:0] captured;
   logic             accept;

   assign accept = (state == IDLE) && start_valid;

   // Moore output decode; increment is gated by pause and by abort so that an
   // aborted cycle never advances the counter or the run length
   always_comb begin
      start_ready   = (state == IDLE);
      busy          = (state == LOAD) || (state == COUNT);
      done          = (state == DONE);
      aborted       = (state == FLUSH);
      cnt_load      = (state == LOAD);
      cnt_data      = (state == LOAD) ? captured : '0;
      cnt_increment = (state == COUNT) && !pause && !abort;
      cnt_clear     = clear || (state == FLUSH);
   end

   // Sequencer state, captured start value and run-length accounting
   always_ff @(posedge clock) begin
      if (clear) begin
         state    <= IDLE;
         captured <= '0;
         run_len  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  captured <= start_value;
                  run_len  <= '0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               state <= abort ? FLUSH : COUNT;
            end
            COUNT: begin
               if (abort) begin
                  state <= FLUSH;
               end else if (cnt_increment) begin
                  run_len <= run_len + (WIDTH+1)'(1);
                  // carry with a stalled increment is not a real wrap
                  if (cnt_carry) begin
                     state <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            FLUSH:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   counter_shadow_check #(
      .WIDTH (WIDTH)
   ) u_shadow (
      .clock         (clock),
      .clear         (clear),
      .capture       (accept),
      .capture_value (start_value),
      .advance       (cnt_increment),
      .check_en      (state == COUNT),
      .cnt_value     (cnt_value),
      .mismatch      (mismatch)
   );

endmodule
`default_nettype wire

// File: tb/tb_counter_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_load_sequencer
// Purpose  : Directed bench pairing the sequencer with a behavioural 4-bit
//            parallel-load counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_load_sequencer;

   logic       clock = 1'b0;
   logic       clear;
   logic       start_valid;
   logic [3:0] start_value;
   logic       start_ready;
   logic       pause;
   logic       abort;
   logic [3:0] cnt_value;
   logic       cnt_carry;
   logic       cnt_clear;
   logic       cnt_load;
   logic       cnt_increment;
   logic [3:0] cnt_data;
   logic       busy;
   logic       done;
   logic       aborted;
   logic [4:0] run_len;
   logic       mismatch;

   logic [3:0] a;
   logic [3:0] corrupt_mask;

   int checks = 0;
   int errors = 0;

   counter_load_sequencer #(.WIDTH(4)) dut (
      .clock         (clock),
      .clear         (clear),
      .start_valid   (start_valid),
      .start_value   (start_value),
      .start_ready   (start_ready),
      .pause         (pause),
      .abort         (abort),
      .cnt_value     (cnt_value),
      .cnt_carry     (cnt_carry),
      .cnt_clear     (cnt_clear),
      .cnt_load      (cnt_load),
      .cnt_increment (cnt_increment),
      .cnt_data      (cnt_data),
      .busy          (busy),
      .done          (done),
      .aborted       (aborted),
      .run_len       (run_len),
      .mismatch      (mismatch)
   );

   always #5 clock = ~clock;

   // Parallel-load counter: clear > load > increment; carry when all ones
   always @(posedge clock) begin
      if (cnt_clear)          a <= 4'd0;
      else if (cnt_load)      a <= cnt_data;
      else if (cnt_increment) a <= a + 4'd1;
   end

   assign cnt_value = a ^ corrupt_mask;
   assign cnt_carry = &a;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Accept a start value; leaves the bench in the LOAD cycle
   task automatic start_run(input logic [3:0] v);
      start_value = v;
      start_valid = 1'b1;
      tick;
      start_valid = 1'b0;
      checks++;
      if (cnt_load !== 1'b1 || cnt_data !== v || busy !== 1'b1 || start_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_cycle: load=%b data=%0d busy=%b ready=%b required load=1 data=%0d busy=1 ready=0",
                  cnt_load, cnt_data, busy, start_ready, v);
      end
   endtask

   // Tick until done; ticks counts edges after the accept edge, -1 on timeout
   task automatic wait_done(output int ticks);
      ticks = -1;
      for (int i = 1; i <= 40; i++) begin
         tick;
         if (done === 1'b1) begin
            ticks = i;
            break;
         end
         if (aborted === 1'b1) break;
      end
   endtask

   task automatic test_reset;
      clear = 1'b1; start_valid = 1'b0; start_value = 4'd0;
      pause = 1'b0; abort = 1'b0; corrupt_mask = 4'd0;
      tick; tick;
      checks++;
      if (start_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: ready=%b busy=%b done=%b aborted=%b required 1 0 0 0",
                  start_ready, busy, done, aborted);
      end
      checks++;
      if (run_len !== 5'd0 || mismatch !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs: run_len=%0d mismatch=%b required 0 0", run_len, mismatch);
      end
      checks++;
      if (cnt_clear !== 1'b1 || a !== 4'd0 || cnt_data !== 4'd0) begin
         errors++;
         $display("FAIL reset_counter: cnt_clear=%b A=%0d data=%0d required 1 0 0", cnt_clear, a, cnt_data);
      end
      clear = 1'b0;
      #1;
      checks++;
      if (cnt_clear !== 1'b0) begin
         errors++;
         $display("FAIL clear_release: cnt_clear=%b required 0", cnt_clear);
      end
      tick;
   endtask

   task automatic test_basic;
      int t;
      start_run(4'd10);
      wait_done(t);
      checks++;
      if (t !== 7) begin
         errors++;
         $display("FAIL basic_latency: done at tick %0d required 7", t);
      end
      checks++;
      if (run_len !== 5'd6 || a !== 4'd0 || mismatch !== 1'b0 || aborted !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: run_len=%0d A=%0d mismatch=%b aborted=%b required 6 0 0 0",
                  run_len, a, mismatch, aborted);
      end
      tick;
      checks++;
      if (done !== 1'b0 || start_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_pulse: done=%b ready=%b required 0 1", done, start_ready);
      end
   endtask

   task automatic test_start15;
      int t;
      start_run(4'd15);
      wait_done(t);
      checks++;
      if (t !== 2 || run_len !== 5'd1 || a !== 4'd0) begin
         errors++;
         $display("FAIL start15: tick=%0d run_len=%0d A=%0d required 2 1 0", t, run_len, a);
      end
      tick;
   endtask

   task automatic test_pause;
      int         t;
      logic [3:0] a_prev;
      t = -1;
      a_prev = 4'd0;
      start_run(4'd0);
      for (int i = 1; i <= 40; i++) begin
         tick;
         if (done === 1'b1) begin
            t = i;
            break;
         end
         if (i == 6) begin
            checks++;
            if (a !== a_prev) begin
               errors++;
               $display("FAIL pause_hold: A=%0d required %0d", a, a_prev);
            end
         end
         pause = (i >= 5) && (i < 8);
         if (i == 5) begin
            a_prev = a;
            #1;
            checks++;
            if (cnt_increment !== 1'b0) begin
               errors++;
               $display("FAIL pause_incr: increment=%b required 0", cnt_increment);
            end
         end
      end
      pause = 1'b0;
      checks++;
      if (t !== 20 || run_len !== 5'd16 || a !== 4'd0 || mismatch !== 1'b0) begin
         errors++;
         $display("FAIL pause_run: tick=%0d run_len=%0d A=%0d mismatch=%b required 20 16 0 0",
                  t, run_len, a, mismatch);
      end
      tick;
   endtask

   task automatic test_abort;
      start_run(4'd13);
      tick; tick; tick;
      abort = 1'b1;
      #1;
      checks++;
      if (a !== 4'd15 || cnt_carry !== 1'b1 || cnt_increment !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_setup: A=%0d carry=%b increment=%b busy=%b required 15 1 0 1",
                  a, cnt_carry, cnt_increment, busy);
      end
      tick;
      abort = 1'b0;
      checks++;
      if (aborted !== 1'b1 || done !== 1'b0 || cnt_clear !== 1'b1) begin
         errors++;
         $display("FAIL abort_flush: aborted=%b done=%b cnt_clear=%b required 1 0 1", aborted, done, cnt_clear);
      end
      tick;
      checks++;
      if (a !== 4'd0 || run_len !== 5'd2 || aborted !== 1'b0 || done !== 1'b0 || start_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_after: A=%0d run_len=%0d aborted=%b done=%b ready=%b required 0 2 0 0 1",
                  a, run_len, aborted, done, start_ready);
      end
      // abort while loading
      start_run(4'd5);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      checks++;
      if (aborted !== 1'b1 || run_len !== 5'd0) begin
         errors++;
         $display("FAIL abort_load: aborted=%b run_len=%0d required 1 0", aborted, run_len);
      end
      tick;
      checks++;
      if (a !== 4'd0 || start_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_load_after: A=%0d ready=%b required 0 1", a, start_ready);
      end
   endtask

   task automatic test_back_to_back;
      int loads;
      int n;
      bit bad_ready;
      loads = 0; n = -1; bad_ready = 1'b0;
      start_value = 4'd12;
      start_valid = 1'b1;
      tick;
      for (int i = 0; i < 40; i++) begin
         if (cnt_load === 1'b1) loads++;
         if (busy === 1'b1 && start_ready !== 1'b0) bad_ready = 1'b1;
         if (done === 1'b1) begin
            n = i;
            break;
         end
         tick;
      end
      // still held through DONE; drop it once IDLE is reached
      tick;
      start_valid = 1'b0;
      checks++;
      if (n !== 5 || bad_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_run: done at %0d ready_while_busy=%b required 5 0", n, bad_ready);
      end
      tick;
      if (cnt_load === 1'b1) loads++;
      tick;
      if (cnt_load === 1'b1) loads++;
      checks++;
      if (loads !== 1 || busy !== 1'b0 || start_ready !== 1'b1 || run_len !== 5'd4) begin
         errors++;
         $display("FAIL b2b_single: loads=%0d busy=%b ready=%b run_len=%0d required 1 0 1 4",
                  loads, busy, start_ready, run_len);
      end
   endtask

   task automatic test_mismatch_clear;
      start_run(4'd8);
      tick; tick;
      checks++;
      if (mismatch !== 1'b0) begin
         errors++;
         $display("FAIL mm_before: mismatch=%b required 0", mismatch);
      end
      corrupt_mask = 4'd1;
      tick;
      corrupt_mask = 4'd0;
      checks++;
      if (mismatch !== 1'b1) begin
         errors++;
         $display("FAIL mm_set: mismatch=%b required 1", mismatch);
      end
      tick;
      checks++;
      if (mismatch !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mm_sticky: mismatch=%b busy=%b required 1 1", mismatch, busy);
      end
      clear = 1'b1;
      tick;
      clear = 1'b0;
      checks++;
      if (start_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
         errors++;
         $display("FAIL midclear_state: ready=%b busy=%b done=%b aborted=%b required 1 0 0 0",
                  start_ready, busy, done, aborted);
      end
      checks++;
      if (mismatch !== 1'b0 || a !== 4'd0 || run_len !== 5'd0) begin
         errors++;
         $display("FAIL midclear_regs: mismatch=%b A=%0d run_len=%0d required 0 0 0", mismatch, a, run_len);
      end
      tick;
      checks++;
      if (done !== 1'b0 || aborted !== 1'b0 || start_ready !== 1'b1) begin
         errors++;
         $display("FAIL midclear_after: done=%b aborted=%b ready=%b required 0 0 1", done, aborted, start_ready);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_start15;
      test_pause;
      test_abort;
      test_back_to_back;
      test_mismatch_clear;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
